// File: rtl/phy_10g_link_test_ctrl_if.sv
// Signal bundle between the 10G PHY link-test sequencer and its surroundings:
// run control and result reporting, plus the PHY resets, XGMII TX lanes,
// PRBS configuration and receive-status inputs.
interface phy_10g_link_test_ctrl_if #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = 8,
   parameter int ERR_W      = 16
);
   logic                  start;
   logic                  abort;
   logic                  phy_tx_rst;
   logic                  phy_rx_rst;
   logic [DATA_WIDTH-1:0] xgmii_txd;
   logic [CTRL_WIDTH-1:0] xgmii_txc;
   logic                  cfg_tx_prbs31_enable;
   logic                  cfg_rx_prbs31_enable;
   logic                  rx_block_lock;
   logic                  rx_status;
   logic                  rx_high_ber;
   logic [6:0]            rx_error_count;
   logic                  busy;
   logic                  done;
   logic                  pass;
   logic [2:0]            fail_code;
   logic [ERR_W-1:0]      err_total;

   // Sequencer side
   modport master (
      input  start, abort, rx_block_lock, rx_status, rx_high_ber, rx_error_count,
      output phy_tx_rst, phy_rx_rst, xgmii_txd, xgmii_txc,
             cfg_tx_prbs31_enable, cfg_rx_prbs31_enable,
             busy, done, pass, fail_code, err_total
   );

   // PHY / host side
   modport slave (
      output start, abort, rx_block_lock, rx_status, rx_high_ber, rx_error_count,
      input  phy_tx_rst, phy_rx_rst, xgmii_txd, xgmii_txc,
             cfg_tx_prbs31_enable, cfg_rx_prbs31_enable,
             busy, done, pass, fail_code, err_total
   );
endinterface

// File: rtl/phy_10g_link_test_ctrl.sv
// Link bring-up and PRBS31 qualification sequencer for a 10G PHY in loopback.
// Resets the PHY, waits for block lock then rx_status, lets the PRBS checker
// settle, then counts PRBS errors for a fixed window and reports pass/fail.
module phy_10g_link_test_ctrl #(
   parameter int DATA_WIDTH    = 64,
   parameter int CTRL_WIDTH    = 8,
   parameter int RESET_CYCLES  = 16,
   parameter int LOCK_TIMEOUT  = 4096,
   parameter int SETTLE_CYCLES = 64,
   parameter int TEST_CYCLES   = 1024,
   parameter int ERR_W         = 16,
   parameter int ERR_THRESHOLD = 0
) (
   input logic                      clk,
   input logic                      rst_n,
   phy_10g_link_test_ctrl_if.master bus
);
   localparam int CNT_W = $clog2(RESET_CYCLES + LOCK_TIMEOUT + SETTLE_CYCLES + TEST_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TEST_LAST   = CNT_W'(TEST_CYCLES - 1);
   localparam logic [ERR_W-1:0] ERR_LIMIT   = ERR_W'(ERR_THRESHOLD);
   localparam logic [DATA_WIDTH-1:0] IDLE_TXD = {CTRL_WIDTH{8'h07}};
   localparam logic [CTRL_WIDTH-1:0] IDLE_TXC = {CTRL_WIDTH{1'b1}};

   localparam logic [2:0] FC_NONE      = 3'd0;
   localparam logic [2:0] FC_LOCK_TO   = 3'd1;
   localparam logic [2:0] FC_STATUS_TO = 3'd2;
   localparam logic [2:0] FC_LOCK_LOST = 3'd3;
   localparam logic [2:0] FC_HIGH_BER  = 3'd4;
   localparam logic [2:0] FC_ERR_THR   = 3'd5;
   localparam logic [2:0] FC_ABORT     = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_RESET       = 3'd1,
      ST_WAIT_LOCK   = 3'd2,
      ST_WAIT_STATUS = 3'd3,
      ST_SETTLE      = 3'd4,
      ST_TEST        = 3'd5,
      ST_DONE        = 3'd6,
      ST_FAIL        = 3'd7
   } state_t;

   // Error accumulation sticks at all-ones instead of wrapping.
   function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc,
                                                 input logic [6:0]       inc);
      logic [ERR_W:0] wide;
      wide = {1'b0, acc} + (ERR_W+1)'(inc);
      if (wide[ERR_W]) begin
         sat_add = {ERR_W{1'b1}};
      end else begin
         sat_add = wide[ERR_W-1:0];
      end
   endfunction

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_phy_rst;
   logic [DATA_WIDTH-1:0] r_txd;
   logic [CTRL_WIDTH-1:0] r_txc;
   logic             r_prbs;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [2:0]       r_fail_code;
   logic [ERR_W-1:0] r_err_total;

   logic             w_fail;
   logic [2:0]       w_fail_code;
   logic [ERR_W-1:0] w_sum;

   assign w_sum = sat_add(r_err_total, bus.rx_error_count);

   // Decide whether this cycle ends the run in failure; abort outranks everything,
   // lock loss outranks high BER.
   always_comb begin
      w_fail      = 1'b0;
      w_fail_code = FC_NONE;
      case (r_state)
         ST_RESET: begin
            if (bus.abort) begin
               w_fail      = 1'b1;
               w_fail_code = FC_ABORT;
            end else begin
               w_fail      = 1'b0;
            end
         end
         ST_WAIT_LOCK: begin
            if (bus.abort) begin
               w_fail      = 1'b1;
               w_fail_code = FC_ABORT;
            end else if (!bus.rx_block_lock && (r_cnt == LOCK_LAST)) begin
               w_fail      = 1'b1;
               w_fail_code = FC_LOCK_TO;
            end else begin
               w_fail      = 1'b0;
            end
         end
         ST_WAIT_STATUS: begin
            if (bus.abort) begin
               w_fail      = 1'b1;
               w_fail_code = FC_ABORT;
            end else if (!bus.rx_status && (r_cnt == LOCK_LAST)) begin
               w_fail      = 1'b1;
               w_fail_code = FC_STATUS_TO;
            end else begin
               w_fail      = 1'b0;
            end
         end
         ST_SETTLE, ST_TEST: begin
            if (bus.abort) begin
               w_fail      = 1'b1;
               w_fail_code = FC_ABORT;
            end else if (!bus.rx_block_lock) begin
               w_fail      = 1'b1;
               w_fail_code = FC_LOCK_LOST;
            end else if (bus.rx_high_ber) begin
               w_fail      = 1'b1;
               w_fail_code = FC_HIGH_BER;
            end else begin
               w_fail      = 1'b0;
            end
         end
         default: begin
            w_fail      = 1'b0;
            w_fail_code = FC_NONE;
         end
      endcase
   end

   // Sequencer state, phase counter and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_phy_rst   <= 1'b1;
         r_txd       <= IDLE_TXD;
         r_txc       <= IDLE_TXC;
         r_prbs      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail_code <= FC_NONE;
         r_err_total <= '0;
      end else begin
         r_done <= 1'b0;
         r_txd  <= IDLE_TXD;
         r_txc  <= IDLE_TXC;
         if (w_fail) begin
            r_state     <= ST_FAIL;
            r_cnt       <= '0;
            r_fail_code <= w_fail_code;
            r_pass      <= 1'b0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_prbs      <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_phy_rst <= 1'b1;
                  r_cnt     <= '0;
                  if (bus.start) begin
                     r_state     <= ST_RESET;
                     r_busy      <= 1'b1;
                     r_pass      <= 1'b0;
                     r_fail_code <= FC_NONE;
                     r_err_total <= '0;
                  end else begin
                     r_state     <= ST_IDLE;
                  end
               end
               ST_RESET: begin
                  if (r_cnt == RESET_LAST) begin
                     r_state   <= ST_WAIT_LOCK;
                     r_phy_rst <= 1'b0;
                     r_cnt     <= '0;
                  end else begin
                     r_cnt     <= r_cnt + CNT_ONE;
                  end
               end
               ST_WAIT_LOCK: begin
                  if (bus.rx_block_lock) begin
                     r_state <= ST_WAIT_STATUS;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt   <= r_cnt + CNT_ONE;
                  end
               end
               ST_WAIT_STATUS: begin
                  if (bus.rx_status) begin
                     r_state <= ST_SETTLE;
                     r_prbs  <= 1'b1;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt   <= r_cnt + CNT_ONE;
                  end
               end
               ST_SETTLE: begin
                  if (r_cnt == SETTLE_LAST) begin
                     r_state <= ST_TEST;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt   <= r_cnt + CNT_ONE;
                  end
               end
               ST_TEST: begin
                  // The last sample is folded in before the threshold compare.
                  r_err_total <= w_sum;
                  if (r_cnt == TEST_LAST) begin
                     r_state     <= ST_DONE;
                     r_cnt       <= '0;
                     r_done      <= 1'b1;
                     r_busy      <= 1'b0;
                     r_prbs      <= 1'b0;
                     r_pass      <= (w_sum <= ERR_LIMIT);
                     r_fail_code <= (w_sum <= ERR_LIMIT) ? FC_NONE : FC_ERR_THR;
                  end else begin
                     r_cnt       <= r_cnt + CNT_ONE;
                  end
               end
               ST_DONE, ST_FAIL: begin
                  r_state   <= ST_IDLE;
                  r_phy_rst <= 1'b1;
               end
               default: begin
                  r_state   <= ST_IDLE;
                  r_phy_rst <= 1'b1;
                  r_busy    <= 1'b0;
                  r_prbs    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.phy_tx_rst           = r_phy_rst;
   assign bus.phy_rx_rst           = r_phy_rst;
   assign bus.xgmii_txd            = r_txd;
   assign bus.xgmii_txc            = r_txc;
   assign bus.cfg_tx_prbs31_enable = r_prbs;
   assign bus.cfg_rx_prbs31_enable = r_prbs;
   assign bus.busy                 = r_busy;
   assign bus.done                 = r_done;
   assign bus.pass                 = r_pass;
   assign bus.fail_code            = r_fail_code;
   assign bus.err_total            = r_err_total;
endmodule

// File: doc/phy_10g_link_test_ctrl.md
Name: phy_10g_link_test_ctrl

Overview:
Sequencer that brings up and qualifies an eth_phy_10g instance in loopback: it resets the PHY, drives XGMII idles, waits for block lock and rx_status, then runs a timed PRBS31 test. During that test it accumulates rx_error_count and reports pass/fail with a failure code. It sits beside the PHY, owning its resets, XGMII TX inputs and PRBS config bits.

Parameters:
DATA_WIDTH, 64, XGMII data width (fixed 64)
CTRL_WIDTH, 8, XGMII control width (DATA_WIDTH/8)
RESET_CYCLES, 16, cycles PHY resets are held asserted
LOCK_TIMEOUT, 4096, max cycles to wait for rx_block_lock, then separately for rx_status
SETTLE_CYCLES, 64, cycles after PRBS enable during which errors are ignored
TEST_CYCLES, 1024, cycles of counted PRBS test
ERR_W, 16, width of error accumulator
ERR_THRESHOLD, 0, max tolerated accumulated errors for pass

Ports:
clk  in  1  single clock; drives PHY tx_clk and rx_clk
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a test run when idle
abort  in  1  pulse; terminates an active run
phy_tx_rst  out  1  active-high PHY TX reset
phy_rx_rst  out  1  active-high PHY RX reset
xgmii_txd  out  DATA_WIDTH  XGMII TX data to PHY
xgmii_txc  out  CTRL_WIDTH  XGMII TX control to PHY
cfg_tx_prbs31_enable  out  1  PHY TX PRBS31 enable
cfg_rx_prbs31_enable  out  1  PHY RX PRBS31 checker enable
rx_block_lock  in  1  from PHY
rx_status  in  1  from PHY
rx_high_ber  in  1  from PHY
rx_error_count  in  7  per-cycle PRBS bit-error count from PHY
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
pass  out  1  result of last run, held until next start
fail_code  out  3  reason for last failure, held until next start
err_total  out  ERR_W  saturating sum of counted errors, last run

Behaviour:
- Reset (rst_n low, async): state IDLE; phy_tx_rst=phy_rx_rst=1; xgmii_txd=64'h0707070707070707, xgmii_txc=8'hFF; PRBS enables 0; busy=done=pass=0; fail_code=0; err_total=0; all counters 0.
- All outputs registered; state change visible on outputs the cycle after the causing input is sampled.
- XGMII outputs are always the idle word above; never any other value.
- States:
  - IDLE: PHY resets held. start=1 -> RESET; clear pass, fail_code, err_total; busy=1.
  - RESET: resets asserted exactly RESET_CYCLES cycles -> WAIT_LOCK, resets deasserted.
  - WAIT_LOCK: rx_block_lock=1 -> WAIT_STATUS (counter cleared). Counter reaching LOCK_TIMEOUT -> FAIL, code 1.
  - WAIT_STATUS: rx_status=1 -> SETTLE, both PRBS enables set to 1. Timeout LOCK_TIMEOUT -> FAIL, code 2.
  - SETTLE: SETTLE_CYCLES cycles, rx_error_count ignored -> TEST.
  - TEST: each cycle err_total += rx_error_count (zero-extended), saturating at all-ones. After TEST_CYCLES cycles -> DONE.
  - DONE: pass = (err_total <= ERR_THRESHOLD); fail_code = 0 if pass else 5. done=1 one cycle. PRBS enables cleared; -> IDLE.
  - FAIL: pass=0, fail_code latched, done=1 one cycle, PRBS enables cleared -> IDLE.
- Monitoring in SETTLE and TEST: rx_block_lock=0 -> FAIL code 3; rx_high_ber=1 -> FAIL code 4. Lock loss takes priority over high_ber.
- Final-cycle accumulation: the TEST-cycle error sample is added before the pass compare.
- abort in any non-IDLE state -> FAIL code 6, with priority over every other transition that cycle. abort in IDLE is ignored.
- start while busy is ignored. start and abort together in IDLE: the run starts.
- On return to IDLE, PHY resets re-assert the following cycle. busy deasserts in the same cycle done pulses.
- fail_code encoding: 0 none, 1 lock timeout, 2 status timeout, 3 lock lost, 4 high BER, 5 error threshold, 6 aborted.
- rst_n asserted mid-run: immediate return to reset values; no done pulse.

Test Plan:
- PHY loopback serdes_tx to serdes_rx, start pulse -> phy resets high 16 cycles, lock and status reached, PRBS enables high for 64+1024 cycles; done pulse with pass=1, fail_code=0, err_total=0.
- rx_block_lock tied 0, start -> done after 16+4096 cycles, pass=0, fail_code=1, PRBS enables never asserted.
- Model forces rx_error_count=3 for 5 TEST cycles -> err_total=15, pass=0, fail_code=5. Repeat with ERR_THRESHOLD=15 -> pass=1. Same injection in SETTLE only -> err_total=0.
- ERR_W=8, rx_error_count=127 every TEST cycle -> err_total saturates at 8'hFF without wrap.
- Drop rx_block_lock mid-TEST -> next cycle FAIL, fail_code=3. Assert rx_high_ber together with it -> code 3. high_ber alone -> code 4.
- abort during WAIT_LOCK -> fail_code=6, done one cycle. rst_n low mid-TEST -> all outputs to reset values asynchronously, no done. Then start -> normal pass run.
